// File: rtl/dmem_pipelined.sv
// Single-port data memory with valid/ready request and response channels, byte strobes,
// 1-2 cycle read latency and an in-order response FIFO. DMEM_INIT_CLEAR_EN adds a zero-fill at reset.
module dmem_pipelined #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int FD  = RD_LAT + 1;
  localparam int PW  = $clog2(FD);
  localparam int OW  = $clog2(FD + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0]     idx;
  logic              addr_err;
  logic              accept;
  logic              pop;
  logic              clearing;
  logic [IW-1:0]     clr_cnt;
  logic [DATA_W-1:0] rd_word;

  assign idx      = req_addr[OFF +: IW];
  assign addr_err = (|req_addr[OFF-1:0]) || (|(req_addr >> (OFF + IW)));
  assign accept   = req_valid && req_ready;
  assign pop      = rsp_valid && rsp_ready;

  // Stores and errors return zero data, so the response word is decided at accept time.
  always_comb begin
    rd_word = '0;
    if (!req_we && !addr_err) rd_word = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_we && !addr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  logic              push;
  logic              push_err;
  logic [DATA_W-1:0] push_data;

  generate
    if (RD_LAT == 2) begin : g_stage
      logic              st_valid;
      logic              st_err;
      logic [DATA_W-1:0] st_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_valid <= 1'b0;
          st_err   <= 1'b0;
          st_data  <= '0;
        end else begin
          st_valid <= accept;
          st_err   <= addr_err;
          st_data  <= rd_word;
        end
      end

      assign push      = st_valid;
      assign push_err  = st_err;
      assign push_data = st_data;
    end else begin : g_direct
      assign push      = accept;
      assign push_err  = addr_err;
      assign push_data = rd_word;
    end
  endgenerate

  logic [DATA_W-1:0] fifo_data [FD];
  logic [FD-1:0]     fifo_err;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [OW-1:0]     fcnt;
  logic [OW-1:0]     occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= push_data;
      fifo_err[wptr]  <= push_err;
    end
  end

  // occ counts everything accepted but not consumed, including the in-flight stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rsp_valid = (fcnt != '0);
  assign rsp_rdata = rsp_valid ? fifo_data[rptr] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rptr];
  assign req_ready = init_done && (occ < OW'(FD));

`ifdef DMEM_INIT_CLEAR_EN
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH - 1)) state <= READY;
    end
  end

  assign clearing  = (state == CLEAR);
  assign init_done = (state == READY);
`else
  assign clearing  = 1'b0;
  assign clr_cnt   = '0;
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_dmem_pipelined.sv
// Self-checking bench for dmem_pipelined: directed cases plus randomized traffic
// checked against a queue-based response model and a word-array memory model.
module tb_dmem_pipelined;

  localparam int RD_LAT = 1;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1024;
`endif
  localparam int NW = (DEPTH < 32) ? DEPTH : 32;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  dmem_pipelined #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          vis;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int          edge_cnt = 0;
  logic [63:0] model_mem [NW];
  rsp_t        exp_q [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Drives one cycle, checks handshake outputs against the model, then advances one edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input logic rr, output logic acc);
    rsp_t r;
    logic bad;
    int   w;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    rsp_ready = rr;
    checkOutput("req_ready", {63'b0, req_ready}, {63'b0, (exp_q.size() < RD_LAT + 1)});
    checkOutput("rsp_valid", {63'b0, rsp_valid},
                {63'b0, (exp_q.size() > 0 && exp_q[0].vis <= edge_cnt)});
    if (rsp_valid && rr && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checkOutput("rsp_rdata", rsp_rdata, r.data);
      checkOutput("rsp_err", {63'b0, rsp_err}, {63'b0, r.err});
    end
    acc = v && req_ready;
    if (acc) begin
      bad   = (addr[2:0] != 3'd0) || (addr >= 64'(DEPTH * 8));
      w     = int'(addr >> 3);
      r.vis = edge_cnt + RD_LAT;
      r.err = bad;
      r.data = '0;
      if (!bad && we) begin
        for (int i = 0; i < 8; i++)
          if (strb[i]) model_mem[w][8*i +: 8] = wdata[8*i +: 8];
      end else if (!bad) begin
        r.data = model_mem[w];
      end
      exp_q.push_back(r);
    end
    tick();
  endtask

  task automatic doReq(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 10) begin
      applyStimulus(1'b1, we, addr, wdata, strb, 1'b1, acc);
      n++;
    end
    checkOutput("req_accept", {63'b0, acc}, 64'd1);
  endtask

  task automatic drain;
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, acc);
      n++;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic waitInit;
    int n;
    n = 0;
    while (!init_done && n < 4 * DEPTH + 8) begin
      checkOutput("req_ready_clear", {63'b0, req_ready}, 64'd0);
      tick();
      n++;
    end
`ifdef DMEM_INIT_CLEAR_EN
    checkOutput("init_cycles", 64'(n), 64'(DEPTH));
    for (int i = 0; i < NW; i++) model_mem[i] = '0;
`else
    checkOutput("init_done", {63'b0, init_done}, 64'd1);
`endif
  endtask

  task automatic resetPulse;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        acc;
    int          n_acc;
    int          n;
    int          w;
    logic [63:0] addr;
    int unsigned sel;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    checkOutput("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("reset_rsp_err", {63'b0, rsp_err}, 64'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 64'd0);
    rst_n = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
    repeat (8) tick();
    checkOutput("mid_clear_init_done", {63'b0, init_done}, 64'd0);
    resetPulse();
`endif
    waitInit();

`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < NW; i++) doReq(1'b0, 64'(i * 8), 64'd0, 8'd0);
    drain();
`else
    for (int i = 0; i < NW; i++) doReq(1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF);
    drain();
`endif

    $display("[TB] store/load full word");
    doReq(1'b1, 64'h10, 64'h0000_0000_0000_00A3, 8'hFF);
    doReq(1'b0, 64'h10, 64'd0, 8'd0);
    drain();

    $display("[TB] partial strobe store");
    doReq(1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    doReq(1'b0, 64'h10, 64'd0, 8'd0);
    doReq(1'b1, 64'h18, 64'h1234_5678_9ABC_DEF0, 8'h00);
    doReq(1'b0, 64'h18, 64'd0, 8'd0);
    drain();
    checkOutput("lane_model_0x10", model_mem[2], 64'h0000_0000_FFFF_FFFF);

    $display("[TB] error accesses");
    doReq(1'b0, 64'h13, 64'd0, 8'd0);
    doReq(1'b0, 64'(DEPTH * 8), 64'd0, 8'd0);
    doReq(1'b1, 64'h11, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    doReq(1'b1, 64'(DEPTH * 8) | 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    doReq(1'b0, 64'h10, 64'd0, 8'd0);
    drain();

    $display("[TB] backpressure");
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(n_acc * 8), 64'd0, 8'd0, 1'b0, acc);
      if (acc) n_acc++;
    end
    checkOutput("bp_accepts", 64'(n_acc), 64'(RD_LAT + 1));
    n = 0;
    while (n_acc < 5 && n < 30) begin
      applyStimulus(1'b1, 1'b0, 64'(n_acc * 8), 64'd0, 8'd0, 1'b1, acc);
      if (acc) n_acc++;
      n++;
    end
    checkOutput("bp_total", 64'(n_acc), 64'd5);
    drain();

    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(i * 8), 64'd0, 8'd0, 1'b1, acc);
      if (acc) n_acc++;
    end
    checkOutput("throughput", 64'(n_acc), 64'd8);
    drain();

    $display("[TB] reset with pending responses");
    doReq(1'b1, 64'h20, 64'hCAFE_F00D_0123_4567, 8'hFF);
    drain();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 64'(i * 8), 64'd0, 8'd0, 1'b0, acc);
    resetPulse();
    waitInit();
    doReq(1'b0, 64'h20, 64'd0, 8'd0);
    doReq(1'b0, 64'h10, 64'd0, 8'd0);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      w = int'($urandom_range(0, NW - 1));
      sel = $urandom_range(0, 15);
      addr = 64'(w * 8);
      if (sel == 0) addr = addr + 64'($urandom_range(1, 7));
      else if (sel == 1) addr = addr | (64'(DEPTH * 8) << $urandom_range(0, 3));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr,
                    {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
